sub16_serial: RTL and testbench
===============================

// Module: sub16_serial
//
// PURPOSE
//   Multi-cycle 16-bit subtractor: diff = a - b - bin, with borrow-out, zero and
//   signed-overflow flags. It is the inverse counterpart of the combinational
//   4-bit-slice ripple adder.
//   Operands are captured through a valid/ready handshake. One DIGIT-bit slice is
//   processed per clock, borrow rippling LSB->MSB, so the datapath is one slice wide.
//   The result is presented on a valid/ready output handshake.
//
// PARAMETERS
//   WIDTH  16  operand/result width; must be an integer multiple of DIGIT
//   DIGIT  4   bits processed per clock; STEPS = WIDTH/DIGIT (default 4)
//
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/bin are valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff/bout/zero/ovf are valid
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  a - b - bin, mod 2^WIDTH
//   bout       out  1      unsigned borrow-out: 1 iff a < b + bin
//   zero       out  1      1 iff diff == 0
//   ovf        out  1      two's-complement overflow of the signed subtraction
//
// BEHAVIOUR
//   - Reset (rst=1 at a rising edge), on that edge:
//       state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; zero=0; ovf=0;
//       slice counter=0.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//       IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and bin; counter=0;
//             go to RUN.
//       RUN:  in_ready=0. Each edge computes slice k = counter:
//               {brw, diff[k*DIGIT +: DIGIT]} = a_k - b_k - brw;
//             counter increments. The edge that finishes slice STEPS-1 sets
//             bout/zero/ovf and out_valid=1, and goes to DONE.
//       DONE: out_valid=1. diff and the flags hold stable until out_ready=1.
//             On out_valid&&out_ready go to IDLE; out_valid=0 next cycle.
//   - Latency: out_valid rises exactly STEPS edges after the accepting edge
//     (4 for the defaults). Throughput: one operation per STEPS+2 cycles.
//   - No same-cycle re-accept: in_ready returns one cycle after output handshake.
//   - in_valid, a, b and bin are ignored outside IDLE. Changes to a/b after
//     acceptance do not affect the result.
//   - Flags:
//       ovf  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), computed on the
//              unsaturated difference.
//       zero = reduction-NOR of the final diff.
//   - out_ready held high in IDLE/RUN has no effect.
//   - rst mid-RUN or in DONE aborts the operation: reset values next cycle and the
//     result is discarded.
//   - Corner cases, exact modular arithmetic required:
//       0 - 0 - 1 = 16'hFFFF, bout=1
//       16'hFFFF - 16'hFFFF = 0, zero=1
//
// CONFIGURATION
//   SUB16_SAT_EN  defined: unsigned saturation. When bout=1 the final diff is
//                 forced to 0 (zero=1). bout and ovf are still reported from the
//                 true result. Latency is unchanged.
//                 undefined: diff is the plain modular result; no clamp logic.
//
// TESTING
//   1. rst=1 for 2 cycles -> in_ready=1, out_valid=0, diff=0, all flags 0.
//   2. a=16'h1234, b=16'h0234, bin=0 -> after 4 edges: diff=16'h1000, bout=0,
//      zero=0, ovf=0.
//   3. a=0, b=0, bin=1 -> diff=16'hFFFF, bout=1 (SAT_EN: diff=0, zero=1).
//   4. a=16'h8000, b=16'h0001 -> diff=16'h7FFF, ovf=1, bout=0.
//   5. Hold out_ready=0 for 10 cycles in DONE -> out_valid and diff stay stable;
//      in_valid pulses are ignored. Then out_ready=1 -> IDLE, and the next
//      operand set is accepted.
//   6. Accept a=16'h00FF, b=16'h0001, assert rst after 2 RUN edges -> next cycle
//      out_valid=0, in_ready=1. A new op a=5, b=5 gives diff=0, zero=1.

Source files
------------

// File: rtl/sub16_serial.sv
// sub16_serial: digit-serial subtractor, diff = a - b - bin.
// Each clock handles one DIGIT-bit slice, LSB first, and the borrow ripples
// through a single slice subtractor. Operands come in and the result goes out
// on valid/ready handshakes.
// Build option: define SUB16_SAT_EN to clamp the result to 0 whenever the
// true difference underflows (bout=1). bout and ovf still report the true
// result.

// One DIGIT-bit slice: {bo, d} = a - b - bi
module sub16_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);
  // A negative slice result shows up as a 1 in the extra top bit, which is
  // the borrow into the next slice.
  always_comb {bo, d} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bi};
endmodule

module sub16_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  // Operands are shifted right one slice per step so the slice subtractor
  // always reads the low digit; the sign bits are kept aside for ovf.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             a_msb, b_msb;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] d_k;
  logic             brw_k;
  logic             accept, release_res, last;
  logic [WIDTH-1:0] diff_full, diff_fin;

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign last        = (cnt == CW'(STEPS - 1));

  sub16_slice #(.DIGIT(DIGIT)) u_slice (
    .a  (a_sh[DIGIT-1:0]),
    .b  (b_sh[DIGIT-1:0]),
    .bi (brw),
    .d  (d_k),
    .bo (brw_k)
  );

  // diff fills as a shift register: each new slice enters at the top, so
  // after STEPS steps slice 0 has reached the LSB position.
  generate
    if (STEPS > 1) begin : g_multi
      assign diff_full = {d_k, diff[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign diff_full = d_k;
    end
  endgenerate

`ifdef SUB16_SAT_EN
  // Unsigned saturation: a final borrow means the true result is below zero.
  assign diff_fin = (last && brw_k) ? '0 : diff_full;
`else
  assign diff_fin = diff_full;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, one slice per RUN edge, flags on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      brw   <= bin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      brw  <= brw_k;
      cnt  <= cnt + CW'(1);
      diff <= diff_fin;
      if (last) begin
        bout <= brw_k;
        zero <= ~|diff_fin;
        ovf  <= (a_msb != b_msb) && (diff_full[WIDTH-1] != a_msb);
      end
    end
  end
endmodule

// File: tb/tb_sub16_serial.sv
// Bench for sub16_serial: directed corner cases plus random operands, each
// checked every cycle against a cycle-level behavioural model.
module tb_sub16_serial;
  localparam int W     = 16;
  localparam int D     = 4;
  localparam int STEPS = W / D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout, zero, ovf;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sub16_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_idle = 1'b1;
  bit           m_have = 1'b0;
  int           m_left = 0;
  logic [W-1:0] e_diff = '0;
  logic         e_bout = 1'b0, e_zero = 1'b0, e_ovf = 1'b0;
  logic [W-1:0] p_diff;
  logic         p_bout, p_zero, p_ovf;

  task automatic model_result(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                              output logic [W-1:0] r, output logic br, output logic z,
                              output logic v);
    int full;
    logic [W-1:0] raw;
    full = int'(x) - int'(y) - int'(c);
    raw  = full[W-1:0];
    br   = (full < 0);
    v    = (x[W-1] != y[W-1]) && (raw[W-1] != x[W-1]);
    r    = raw;
`ifdef SUB16_SAT_EN
    if (br) r = '0;
`endif
    z    = (r == '0);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_have = 1'b0; m_left = 0;
      e_diff = '0; e_bout = 1'b0; e_zero = 1'b0; e_ovf = 1'b0;
    end else if (m_have) begin
      if (out_ready) begin m_have = 1'b0; m_idle = 1'b1; end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_have = 1'b1;
        e_diff = p_diff; e_bout = p_bout; e_zero = p_zero; e_ovf = p_ovf;
      end
    end else if (m_idle && in_valid) begin
      model_result(a, b, bin, p_diff, p_bout, p_zero, p_ovf);
      m_left = STEPS;
      m_idle = 1'b0;
    end
  end

  // Compare process: handshakes every cycle, result whenever it is presented
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      cmp("in_ready", 32'(in_ready), 32'(m_idle));
      cmp("out_valid", 32'(out_valid), 32'(m_have));
      if (m_have) begin
        cmp("diff", 32'(diff), 32'(e_diff));
        cmp("bout", 32'(bout), 32'(e_bout));
        cmp("zero", 32'(zero), 32'(e_zero));
        cmp("ovf", 32'(ovf), 32'(e_ovf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) cmp("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One operation. Optional literal check of the result; hold = cycles the
  // result is kept waiting with out_ready low and stray in_valid pulses.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                    input int hold, input bit lit, input logic [W-1:0] xd,
                    input logic xb, input logic xz, input logic xo);
    int n = 0;
    wait_ready();
    a = x; b = y; bin = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      @(negedge clk); n++;
    end
    in_valid = 1'b0;
    if (!out_valid) cmp("out_valid_timeout", 32'(out_valid), 32'd1);
    if (lit) begin
      cmp("lit_diff", 32'(diff), 32'(xd));
      cmp("lit_bout", 32'(bout), 32'(xb));
      cmp("lit_zero", 32'(zero), 32'(xz));
      cmp("lit_ovf", 32'(ovf), 32'(xo));
    end
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Reset for two edges, then reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_diff", 32'(diff), 32'd0);
    cmp("rst_flags", {29'd0, bout, zero, ovf}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    op(16'h1234, 16'h0234, 1'b0, 0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
`ifdef SUB16_SAT_EN
    op(16'h0000, 16'h0000, 1'b1, 0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
`else
    op(16'h0000, 16'h0000, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
`endif
    op(16'h8000, 16'h0001, 1'b0, 0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Long stall in DONE with stray in_valid pulses
    op(16'h4321, 16'h1111, 1'b1, 10, 1'b1, 16'h320F, 1'b0, 1'b0, 1'b0);

    // Abort mid-run: reset after two RUN edges
    wait_ready();
    a = 16'h00FF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_out_valid", 32'(out_valid), 32'd0);
    cmp("abort_in_ready", 32'(in_ready), 32'd1);
    op(16'h0005, 16'h0005, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Random operands, mixing in sign-boundary values
    for (int i = 0; i < 80; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'h7FFF;
      if (i % 8 == 2) rb = ra;
      op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
         1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
